// File: rtl/accel_hex_display.sv
// Averages 2^AVG_LOG2 signed accelerometer samples and shows the result as a
// sign-magnitude decimal on HEX5..HEX0. Define ACCEL_HEX_LZB_EN for leading-zero blanking.
module accel_hex_display #(
   parameter int AVG_LOG2 = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] sample_i,
   input  logic        sample_valid_i,
   output logic        sample_ready_o,
   output logic [7:0]  hex0_o,
   output logic [7:0]  hex1_o,
   output logic [7:0]  hex2_o,
   output logic [7:0]  hex3_o,
   output logic [7:0]  hex4_o,
   output logic [7:0]  hex5_o,
   output logic        disp_valid_o
);

   localparam int AW = 16 + AVG_LOG2;
   localparam int CW = AVG_LOG2 + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'((1 << AVG_LOG2) - 1);
   localparam logic [7:0] SEG_MINUS = 8'hBF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   typedef enum logic [1:0] {
      IDLE,
      SIGN,
      CONV,
      LATCH
   } state_t;

   state_t state_reg;
   state_t state_next;

   logic signed [AW-1:0] acc_reg;
   logic [CW-1:0]        cnt_reg;
   logic                 neg_reg;
   logic [16:0]          mag_reg;
   logic [19:0]          bcd_reg;
   logic [4:0]           step_reg;
   logic [7:0]           seg_reg [6];
   logic                 load_reg;
   logic [7:0]           hex_reg [6];
   logic                 disp_reg;

   logic                 accept;
   logic                 last_sample;
   logic                 conv_done;
   logic signed [AW-1:0] sample_ext;
   logic [15:0]          avg;
   logic [16:0]          avg_ext;
   logic [16:0]          mag_calc;
   logic [19:0]          bcd_adj;
   logic [3:0]           digit [5];
   logic [4:0]           blank;
   logic [7:0]           digit_code [5];

   function automatic logic [7:0] seg7(input logic [3:0] d);
      logic [7:0] code;
      case (d)
         4'd0:    code = 8'hC0;
         4'd1:    code = 8'hF9;
         4'd2:    code = 8'hA4;
         4'd3:    code = 8'hB0;
         4'd4:    code = 8'h99;
         4'd5:    code = 8'h92;
         4'd6:    code = 8'h82;
         4'd7:    code = 8'hF8;
         4'd8:    code = 8'h80;
         4'd9:    code = 8'h90;
         default: code = SEG_BLANK;
      endcase
      return code;
   endfunction

   assign sample_ready_o = (state_reg == IDLE);
   assign accept         = sample_valid_i & sample_ready_o;
   assign last_sample    = accept && (cnt_reg == LAST_CNT);
   assign conv_done      = (step_reg == 5'd16);

   assign sample_ext = AW'($signed(sample_i));
   // Arithmetic shift floors toward -inf; the average always fits in 16 bits.
   assign avg      = 16'(acc_reg >>> AVG_LOG2);
   assign avg_ext  = {avg[15], avg};
   assign mag_calc = avg[15] ? (~avg_ext + 17'd1) : avg_ext;

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_digit
         assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                     (bcd_reg[4*gi +: 4] + 4'd3) : bcd_reg[4*gi +: 4];
         assign digit[gi]      = bcd_reg[4*gi +: 4];
         assign digit_code[gi] = blank[gi] ? SEG_BLANK : seg7(digit[gi]);
      end
   endgenerate

`ifdef ACCEL_HEX_LZB_EN
   // A digit is blank only if it and every more significant digit are zero; units always shown.
   assign blank[4] = (digit[4] == 4'd0);
   generate
      for (gi = 1; gi < 4; gi++) begin : g_lzb
         assign blank[gi] = blank[gi+1] & (digit[gi] == 4'd0);
      end
   endgenerate
   assign blank[0] = 1'b0;
`else
   assign blank = '0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (last_sample) state_next = SIGN;
         SIGN:    state_next = CONV;
         CONV:    if (conv_done) state_next = LATCH;
         LATCH:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_reg  <= '0;
         cnt_reg  <= '0;
         neg_reg  <= 1'b0;
         mag_reg  <= '0;
         bcd_reg  <= '0;
         step_reg <= '0;
         load_reg <= 1'b0;
         disp_reg <= 1'b0;
         for (int i = 0; i < 6; i++) begin
            seg_reg[i] <= SEG_BLANK;
            hex_reg[i] <= SEG_BLANK;
         end
      end else begin
         load_reg <= 1'b0;
         disp_reg <= load_reg;
         if (load_reg) begin
            for (int i = 0; i < 6; i++) begin
               hex_reg[i] <= seg_reg[i];
            end
         end
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  acc_reg <= acc_reg + sample_ext;
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            SIGN: begin
               neg_reg  <= avg[15];
               mag_reg  <= mag_calc;
               bcd_reg  <= '0;
               step_reg <= '0;
               acc_reg  <= '0;
               cnt_reg  <= '0;
            end
            CONV: begin
               bcd_reg  <= 20'({bcd_adj, mag_reg[16]});
               mag_reg  <= {mag_reg[15:0], 1'b0};
               step_reg <= step_reg + 5'd1;
            end
            LATCH: begin
               seg_reg[5] <= neg_reg ? SEG_MINUS : SEG_BLANK;
               for (int i = 0; i < 5; i++) begin
                  seg_reg[i] <= digit_code[i];
               end
               load_reg <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign hex0_o       = hex_reg[0];
   assign hex1_o       = hex_reg[1];
   assign hex2_o       = hex_reg[2];
   assign hex3_o       = hex_reg[3];
   assign hex4_o       = hex_reg[4];
   assign hex5_o       = hex_reg[5];
   assign disp_valid_o = disp_reg;

endmodule
